// File: rtl/rib_arbiter_pkg.sv
// rib_arbiter_pkg: shared widths and pipeline hold codes
// used by the bus arbiter and the PC/IF/ID stages.
package rib_arbiter_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_PC   = 3'b001;
  localparam logic [2:0] HOLD_IF   = 3'b010;
  localparam logic [2:0] HOLD_ID   = 3'b011;

endpackage

// File: rtl/rib_prio_enc.sv
// rib_prio_enc: fixed-priority encoder, lowest set
// index wins; also flags whether any bit is set.
module rib_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) idx = W'(k);
    end
  end

  assign any = |req;

endmodule

// File: rtl/rib_arbiter.sv
// rib_arbiter: fixed-priority RIB master arbiter with
// a single slave port, ack timeout and pipeline hold.
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int NUM_M          = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_M-1:0]      m_req_i,
  input  logic [NUM_M*XLEN-1:0] m_addr_i,
  input  logic [NUM_M-1:0]      m_we_i,
  input  logic [NUM_M*XLEN-1:0] m_wdata_i,
  output logic [XLEN-1:0]       m_rdata_o,
  output logic [NUM_M-1:0]      m_ack_o,
  output logic                  m_err_o,
  output logic                  s_req_o,
  output logic                  s_we_o,
  output logic [XLEN-1:0]       s_addr_o,
  output logic [XLEN-1:0]       s_wdata_o,
  input  logic [XLEN-1:0]       s_rdata_i,
  input  logic                  s_ack_i,
  output logic [2:0]            hold_flag_o
);

  localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   enc_idx;
  logic            enc_any;
  logic [CW-1:0]   cnt;
  logic            timeout;
  logic [NUM_M-1:0] own;
  logic [NUM_M-1:0] pend;

  rib_prio_enc #(
    .N (NUM_M),
    .W (GW)
  ) u_prio_enc (
    .req (m_req_i),
    .idx (enc_idx),
    .any (enc_any)
  );

  assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enc_any) state_nxt = BUSY;
      BUSY:    if (s_ack_i || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant     <= '0;
      cnt       <= '0;
      m_rdata_o <= '0;
      m_err_o   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (enc_any) grant <= enc_idx;
        end
        BUSY: begin
          // a late ack still beats the timeout
          if (s_ack_i) begin
            m_rdata_o <= s_rdata_i;
            m_err_o   <= 1'b0;
          end else if (timeout) begin
            m_rdata_o <= '0;
            m_err_o   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    m_ack_o   = '0;
    own       = '0;
    own[grant] = 1'b1;
    if (state == BUSY) begin
      s_req_o   = 1'b1;
      s_we_o    = m_we_i[grant];
      s_addr_o  = m_addr_i[grant*XLEN +: XLEN];
      s_wdata_o = m_wdata_i[grant*XLEN +: XLEN];
    end
    if (state == RESP) m_ack_o = own;
  end

  // the master being acked no longer counts as pending
  always_comb begin
    pend = m_req_i;
    if (state == RESP) pend = pend & ~own;
    if (state == BUSY) pend = pend | own;
    if (|pend[NUM_M-2:0])     hold_flag_o = HOLD_ID;
    else if (pend[NUM_M-1])   hold_flag_o = HOLD_PC;
    else                      hold_flag_o = HOLD_NONE;
  end

endmodule
